byte_demux8_reg: RTL and testbench
==================================

BYTE_DEMUX8_REG -- requirements
Module: byte_demux8_reg

Interface
REQ-001 The block SHALL provide these ports:
  clk  input  1  single clock; all state updates on rising edge
  rst  input  1  synchronous, active-high reset
  din  input  8  byte to distribute
  din_valid  input  1  din is presented this cycle
  din_ready  output  1  block accepts din this cycle
  sel  input  3  target lane in manual mode
  auto_mode  input  1  1 = lane from internal pointer, 0 = lane from sel
  O0..O7  output  8 each  registered lane bytes
  lane_valid  output  8  bit k set = lane k written since frame start
  frame_done  output  1  one-cycle pulse, all 8 lanes written
REQ-002 The block SHALL have one clock (clk); reset (rst) is synchronous and active-high.
REQ-003 The block SHALL have no parameters; widths are fixed at 8 lanes x 8 bits.

Function
REQ-004 The block SHALL perform an accept when din_valid=1 and din_ready=1 at a rising clk edge; no other condition writes a lane.
REQ-005 On accept, the block SHALL load din into lane L and set lane_valid[L], visible the cycle after the edge (1-cycle latency).
REQ-006 The lane SHALL be L=sel when auto_mode=0, and L=ptr (internal 3-bit pointer) when auto_mode=1.
REQ-007 In auto mode, ptr SHALL increment by 1 per accept, wrapping 7->0; in manual mode, ptr SHALL hold.
REQ-008 Lanes not written SHALL hold their value; O0..O7 SHALL hold across frames until overwritten (not cleared at frame end).
REQ-009 A repeated write to an already-valid lane SHALL overwrite the data; lane_valid is unchanged.
REQ-010 The FSM SHALL have two states: FILL (din_ready=1) and DONE (din_ready=0).
REQ-011 In FILL: if an accept makes lane_valid all ones, next state is DONE; otherwise, stay in FILL.
REQ-012 In DONE, the block SHALL assert frame_done=1 for exactly that one cycle, clear lane_valid to 0 and ptr to 0 at the end of the cycle, and return to FILL.
REQ-013 din_valid while in DONE SHALL be ignored (no write, no ptr change); the source holds din until din_ready=1.
REQ-014 frame_done SHALL be 0 in every cycle except the DONE cycle; back-to-back frames are separated by at least one DONE cycle.
REQ-015 A change of auto_mode mid-frame SHALL take effect on the next accept; ptr and lane_valid are unaffected.
REQ-016 din_ready and frame_done SHALL be decoded from state only, with no combinational path from din_valid, sel or auto_mode.

Reset
REQ-017 rst=1 at a rising edge SHALL force the following, overriding any simultaneous accept:
  O0..O7 = 8'h00; lane_valid = 8'h00; ptr = 0; state = FILL; frame_done = 0.
REQ-018 Reset asserted mid-frame or in DONE SHALL discard the partial frame; din_ready=1 the first cycle after rst deasserts.

Verification
REQ-019 The bench SHALL cover:
  (a) rst, auto_mode=1, 8 consecutive accepts din=8'h10..8'h17 -> O0..O7=10..17; lane_valid=FF after the 8th; frame_done=1 and din_ready=0 the next cycle; lane_valid=00 after that cycle.
  (b) auto_mode=0, sel=5, din=AB, then sel=5, din=CD -> O5=CD, lane_valid=8'h20, no frame_done.
  (c) din_valid held high through DONE with din=EE -> no lane changes in the DONE cycle; EE is written to O0 on the first FILL cycle (ptr=0).
  (d) auto mode, 3 accepts (lanes 0-2), rst pulse, 1 accept din=55 -> all O=00 except O0=55; lane_valid=8'h01.
  (e) auto mode, 4 accepts, switch to manual sel=7 with 1 accept, back to auto with 1 accept -> writes go to lanes 0-3, 7, then 4; lane_valid=8'h9F.
  (f) rst=1 and din_valid=1 on the same edge -> no write; all outputs at reset values.

Source files
------------

// File: rtl/byte_demux8_reg.sv
// Purpose : distributes input bytes into eight registered lanes and pulses
//           frame_done once all eight lanes have been written.
// Latency : 1 cycle from an accepting edge to the lane and lane_valid update.
// Backpressure: din_ready drops for exactly one DONE cycle after a full frame;
//               din_valid in that cycle is ignored and the source must hold.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   din, din_valid     byte to distribute and its qualifier
//   din_ready          high in FILL, low in DONE (decoded from state only)
//   sel, auto_mode     lane select: sel when auto_mode=0, internal pointer when 1
//   O0..O7             registered lane bytes, held across frames
//   lane_valid         bit k set once lane k is written in the current frame
//   frame_done         one-cycle pulse in the DONE state
module byte_demux8_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic [2:0] sel,
    input  logic       auto_mode,
    output logic [7:0] O0,
    output logic [7:0] O1,
    output logic [7:0] O2,
    output logic [7:0] O3,
    output logic [7:0] O4,
    output logic [7:0] O5,
    output logic [7:0] O6,
    output logic [7:0] O7,
    output logic [7:0] lane_valid,
    output logic       frame_done
);

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [7:0]      lane_valid_q, lane_valid_d;
    logic [7:0][7:0] lanes_q, lanes_d;

    logic            accept;
    logic [2:0]      lane;

    // Handshake outputs depend on state alone so no input reaches them
    // combinationally.
    assign din_ready  = (state_q == FILL);
    assign frame_done = (state_q == DONE);

    assign accept = din_valid & din_ready;
    assign lane   = auto_mode ? ptr_q : sel;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        lane_valid_d = lane_valid_q;
        lanes_d      = lanes_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    lanes_d[lane]      = din;
                    lane_valid_d[lane] = 1'b1;
                    // Pointer only advances on auto-mode accepts; the 3-bit
                    // width gives the 7->0 wrap for free.
                    if (auto_mode) begin
                        ptr_d = ptr_q + 3'd1;
                    end
                    if (lane_valid_d == 8'hFF) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Lane data is kept; only the frame bookkeeping restarts.
                lane_valid_d = 8'h00;
                ptr_d        = 3'd0;
                state_d      = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            ptr_q        <= 3'd0;
            lane_valid_q <= 8'h00;
            lanes_q      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            lane_valid_q <= lane_valid_d;
            lanes_q      <= lanes_d;
        end
    end

    assign lane_valid = lane_valid_q;
    assign O0 = lanes_q[0];
    assign O1 = lanes_q[1];
    assign O2 = lanes_q[2];
    assign O3 = lanes_q[3];
    assign O4 = lanes_q[4];
    assign O5 = lanes_q[5];
    assign O6 = lanes_q[6];
    assign O7 = lanes_q[7];

endmodule

// File: tb/tb_byte_demux8_reg.sv
module tb_byte_demux8_reg;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [2:0] sel;
    logic       auto_mode;
    logic [7:0] O0, O1, O2, O3, O4, O5, O6, O7;
    logic [7:0] lane_valid;
    logic       frame_done;

    byte_demux8_reg dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sel        (sel),
        .auto_mode  (auto_mode),
        .O0         (O0),
        .O1         (O1),
        .O2         (O2),
        .O3         (O3),
        .O4         (O4),
        .O5         (O5),
        .O6         (O6),
        .O7         (O7),
        .lane_valid (lane_valid),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] dut_o [8];
    assign dut_o[0] = O0;
    assign dut_o[1] = O1;
    assign dut_o[2] = O2;
    assign dut_o[3] = O3;
    assign dut_o[4] = O4;
    assign dut_o[5] = O5;
    assign dut_o[6] = O6;
    assign dut_o[7] = O7;

    int n_vec;
    int n_bad;

    // ---------------- reference model ----------------
    // Frame tracked as the set of lanes written so far plus a pending
    // "frame complete" flag; pointer kept as a plain integer mod 8.
    logic [7:0] m_o [8];
    bit         m_written [8];
    int         m_ptr;
    bit         m_complete;

    function automatic int written_count();
        int c = 0;
        for (int k = 0; k < 8; k++) if (m_written[k]) c++;
        return c;
    endfunction

    function automatic logic [7:0] written_mask();
        logic [7:0] m = 8'h00;
        for (int k = 0; k < 8; k++) if (m_written[k]) m[k] = 1'b1;
        return m;
    endfunction

    task automatic model_edge(input bit r, input bit v, input logic [7:0] d,
                              input logic [2:0] s, input bit a);
        int l;
        if (r) begin
            for (int k = 0; k < 8; k++) begin
                m_o[k]       = 8'h00;
                m_written[k] = 1'b0;
            end
            m_ptr      = 0;
            m_complete = 1'b0;
        end else if (m_complete) begin
            // Frame-complete cycle: inputs ignored, bookkeeping restarts.
            for (int k = 0; k < 8; k++) m_written[k] = 1'b0;
            m_ptr      = 0;
            m_complete = 1'b0;
        end else if (v) begin
            l = a ? m_ptr : int'(s);
            m_o[l]       = d;
            m_written[l] = 1'b1;
            if (a) m_ptr = (m_ptr + 1) % 8;
            if (written_count() == 8) m_complete = 1'b1;
        end
    endtask

    task automatic check_model(input string tag, input int idx);
        bit ok = 1'b1;
        for (int k = 0; k < 8; k++) if (dut_o[k] !== m_o[k]) ok = 1'b0;
        if (lane_valid !== written_mask()) ok = 1'b0;
        if (din_ready !== !m_complete) ok = 1'b0;
        if (frame_done !== m_complete) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL model-%s #%0d: got O=%h %h %h %h %h %h %h %h lv=%h rdy=%b fd=%b; want O=%h %h %h %h %h %h %h %h lv=%h rdy=%b fd=%b",
                     tag, idx, O0, O1, O2, O3, O4, O5, O6, O7, lane_valid, din_ready, frame_done,
                     m_o[0], m_o[1], m_o[2], m_o[3], m_o[4], m_o[5], m_o[6], m_o[7],
                     written_mask(), !m_complete, m_complete);
        end
    endtask

    // Drive inputs, take one rising edge, then sample 1 time unit later.
    task automatic step(input bit r, input bit v, input logic [7:0] d,
                        input logic [2:0] s, input bit a);
        rst = r; din_valid = v; din = d; sel = s; auto_mode = a;
        @(posedge clk);
        model_edge(r, v, d, s, a);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         r;
        bit         v;
        logic [7:0] d;
        logic [2:0] s;
        bit         a;
        logic [7:0] e_lv;
        bit         e_rdy;
        bit         e_fd;
        int         e_idx;   // lane to check, -1 = none
        logic [7:0] e_dat;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(bit r, bit v, logic [7:0] d, logic [2:0] s, bit a,
                                logic [7:0] lv, bit rdy, bit fd, int idx, logic [7:0] dat);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.s = s; x.a = a;
        x.e_lv = lv; x.e_rdy = rdy; x.e_fd = fd; x.e_idx = idx; x.e_dat = dat;
        return x;
    endfunction

    initial begin
        logic [7:0] lv_acc;
        n_vec = 0;
        n_bad = 0;
        m_ptr = 0;
        m_complete = 1'b0;
        for (int k = 0; k < 8; k++) begin
            m_o[k] = 8'h00;
            m_written[k] = 1'b0;
        end
        rst = 1'b1; din_valid = 1'b0; din = 8'h00; sel = 3'd0; auto_mode = 1'b0;

        // reset
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'h00));
        // (a) auto fill 10..17
        lv_acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            lv_acc[i] = 1'b1;
            vecs.push_back(mk(0, 1, 8'h10 + 8'(i), 0, 1, lv_acc, (i != 7), (i == 7), i, 8'h10 + 8'(i)));
        end
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 1, 0, 0, 8'h10));
        // (b) manual double write to lane 5
        vecs.push_back(mk(0, 1, 8'hAB, 5, 0, 8'h20, 1, 0, 5, 8'hAB));
        vecs.push_back(mk(0, 1, 8'hCD, 5, 0, 8'h20, 1, 0, 5, 8'hCD));
        // (f) reset wins over a simultaneous accept
        vecs.push_back(mk(1, 1, 8'h99, 5, 0, 8'h00, 1, 0, 5, 8'h00));
        // (c) fill, then din_valid held through DONE
        lv_acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            lv_acc[i] = 1'b1;
            vecs.push_back(mk(0, 1, 8'h20 + 8'(i), 0, 1, lv_acc, (i != 7), (i == 7), i, 8'h20 + 8'(i)));
        end
        vecs.push_back(mk(0, 1, 8'hEE, 0, 1, 8'h00, 1, 0, 0, 8'h20));
        vecs.push_back(mk(0, 1, 8'hEE, 0, 1, 8'h01, 1, 0, 0, 8'hEE));
        // (d) partial frame discarded by reset
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h00, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'h31, 0, 1, 8'h01, 1, 0, 0, 8'h31));
        vecs.push_back(mk(0, 1, 8'h32, 0, 1, 8'h03, 1, 0, 1, 8'h32));
        vecs.push_back(mk(0, 1, 8'h33, 0, 1, 8'h07, 1, 0, 2, 8'h33));
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h00, 1, 0, 1, 8'h00));
        vecs.push_back(mk(0, 1, 8'h55, 0, 1, 8'h01, 1, 0, 0, 8'h55));
        // (e) auto x4, manual sel=7, auto again -> lane 4
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h00, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'h40, 0, 1, 8'h01, 1, 0, 0, 8'h40));
        vecs.push_back(mk(0, 1, 8'h41, 0, 1, 8'h03, 1, 0, 1, 8'h41));
        vecs.push_back(mk(0, 1, 8'h42, 0, 1, 8'h07, 1, 0, 2, 8'h42));
        vecs.push_back(mk(0, 1, 8'h43, 0, 1, 8'h0F, 1, 0, 3, 8'h43));
        vecs.push_back(mk(0, 1, 8'h47, 7, 0, 8'h8F, 1, 0, 7, 8'h47));
        vecs.push_back(mk(0, 1, 8'h44, 7, 1, 8'h9F, 1, 0, 4, 8'h44));

        foreach (vecs[i]) begin
            bit ok;
            step(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].a);
            ok = (lane_valid === vecs[i].e_lv) && (din_ready === vecs[i].e_rdy) &&
                 (frame_done === vecs[i].e_fd);
            if (vecs[i].e_idx >= 0 && dut_o[vecs[i].e_idx] !== vecs[i].e_dat) ok = 1'b0;
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL table #%0d: got lv=%h rdy=%b fd=%b O%0d=%h; want lv=%h rdy=%b fd=%b O%0d=%h",
                         i, lane_valid, din_ready, frame_done, vecs[i].e_idx,
                         (vecs[i].e_idx >= 0) ? dut_o[vecs[i].e_idx] : 8'h00,
                         vecs[i].e_lv, vecs[i].e_rdy, vecs[i].e_fd, vecs[i].e_idx, vecs[i].e_dat);
            end
            check_model("table", i);
        end

        // ---------------- randomized run ----------------
        for (int i = 0; i < 600; i++) begin
            bit         r;
            bit         v;
            logic [7:0] d;
            logic [2:0] s;
            bit         a;
            r = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            s = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 2) != 0);
            step(r, v, d, s, a);
            check_model("rand", i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
